// File: rtl/wb_uart_tx_pkg.sv
// Shared definitions for the Wishbone UART transmitter: FSM states,
// register map offsets and STATUS bit layout.
package wb_uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam logic [3:0] REG_DATA   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h4;
    localparam logic [3:0] REG_DIV    = 4'h8;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;
    localparam int ST_CNT_W   = 5;

    // A programmed divisor of zero would stall the bit timer, so run it as 1.
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. Push when full and pop when
// empty are ignored, so callers may drive them unconditionally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone-mapped 8N1 UART transmitter with a small TX FIFO, a
// programmable baud divisor and a drain interrupt.
module wb_uart_tx
    import wb_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        tx_o,
    output logic        tx_oeb_o,
    output logic        irq_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Bus decode. Every strobe is acknowledged, whether or not it lands in
    // our window; only in-window accesses touch registers.
    logic       req;
    logic       in_win;
    logic [3:0] off;
    logic       wr_en;
    logic       rd_en;

    assign req    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign in_win = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign off    = wbs_adr_i[3:0];
    assign wr_en  = req & in_win & wbs_we_i;
    assign rd_en  = req & in_win & ~wbs_we_i;

    logic [15:0] div_q;
    logic        ovf;

    logic          fifo_push;
    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    tx_state_e   state;
    logic [7:0]  shreg;
    logic [15:0] cnt;
    logic [15:0] reload;
    logic [2:0]  idx;
    logic        busy;

    // Full is judged before any same-cycle pop, so a push while full drops.
    assign fifo_push = wr_en & (off == REG_DATA) & wbs_sel_i[0] & ~fifo_full;
    assign fifo_pop  = (state == IDLE) & ~fifo_empty;
    assign busy      = (state != IDLE);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (fifo_push),
        .din   (wbs_dat_i[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // STATUS word assembled from live state.
    logic [31:0] status;
    always_comb begin
        status                               = '0;
        status[ST_BUSY]                      = busy;
        status[ST_FULL]                      = fifo_full;
        status[ST_EMPTY]                     = fifo_empty;
        status[ST_OVF]                       = ovf;
        status[ST_CNT_LSB +: ST_CNT_W]       = ST_CNT_W'(fifo_count);
    end

    // Register file, ack and read data; reads capture state at the strobe edge.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            div_q     <= 16'(CLK_DIV);
            ovf       <= 1'b0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= '0;
            if (rd_en) begin
                case (off)
                    REG_STATUS: wbs_dat_o <= status;
                    REG_DIV:    wbs_dat_o <= {16'h0, div_q};
                    default:    wbs_dat_o <= '0;
                endcase
            end
            if (wr_en) begin
                if (off == REG_DIV && wbs_sel_i[1:0] == 2'b11)
                    div_q <= wbs_dat_i[15:0];
                if (off == REG_STATUS && wbs_sel_i[0] && wbs_dat_i[ST_OVF])
                    ovf <= 1'b0;
                if (off == REG_DATA && wbs_sel_i[0] && fifo_full)
                    ovf <= 1'b1;
            end
        end
    end

    // Transmit FSM. tx_o is registered from the current state, so the line
    // trails the state by one cycle and a frame spans exactly 10 bit times.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state  <= IDLE;
            tx_o   <= 1'b1;
            shreg  <= '0;
            cnt    <= '0;
            reload <= '0;
            idx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx_o <= 1'b1;
                    if (!fifo_empty) begin
                        shreg  <= fifo_dout;
                        reload <= eff_div(div_q);
                        cnt    <= eff_div(div_q) - 16'd1;
                        idx    <= '0;
                        state  <= START;
                    end
                end
                START: begin
                    tx_o <= 1'b0;
                    if (cnt == 16'd0) begin
                        cnt   <= reload - 16'd1;
                        state <= DATA;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                DATA: begin
                    tx_o <= shreg[0];
                    if (cnt == 16'd0) begin
                        cnt   <= reload - 16'd1;
                        shreg <= {1'b0, shreg[7:1]};
                        idx   <= idx + 3'd1;
                        if (idx == 3'd7)
                            state <= STOP;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                STOP: begin
                    tx_o <= 1'b1;
                    if (cnt == 16'd0)
                        state <= IDLE;
                    else
                        cnt <= cnt - 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tx_oeb_o = 1'b0;
    assign irq_o    = fifo_empty & ~busy;

    // Bus bits with no function in this register map.
    logic unused_ok;
    assign unused_ok = ^{wbs_dat_i[31:16], wbs_sel_i[3:2]};

endmodule

// File: tb/tb_wb_uart_tx.sv
// Bench for wb_uart_tx: directed register/latency checks plus randomized
// frames checked against a bit-level model of 8N1 framing built from a
// recorded trace of the serial line.
module tb_wb_uart_tx;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int LOGN = 20000;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_cyc, wb_stb, wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr, wb_wdat;
    logic        ack;
    logic [31:0] rdat_o;
    logic        tx_o, tx_oeb, irq;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_n   = 0;
    logic txlog [0:LOGN-1];

    always #5 clk = ~clk;

    wb_uart_tx #(.BASE_ADDR(BASE), .CLK_DIV(16), .FIFO_DEPTH(4)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (wb_cyc),
        .wbs_stb_i (wb_stb),
        .wbs_we_i  (wb_we),
        .wbs_sel_i (wb_sel),
        .wbs_adr_i (wb_adr),
        .wbs_dat_i (wb_wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat_o),
        .tx_o      (tx_o),
        .tx_oeb_o  (tx_oeb),
        .irq_o     (irq)
    );

    // txlog[k] holds the line value after posedge number k.
    always @(posedge clk) cyc_n <= cyc_n + 1;
    always @(negedge clk) if (cyc_n < LOGN) txlog[cyc_n] = tx_o;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected STATUS from a high-level view: busy flag, queued count, overflow.
    function automatic logic [31:0] st_exp(input bit busy, input int count, input bit ovf);
        return {23'b0, 5'(count), ovf, count == 0, count == 4, busy};
    endfunction

    // One Wishbone classic transfer; n_at is the index of the edge that sampled it.
    task automatic xfer(input logic we_, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output logic [31:0] rd, output int n_at);
        logic got;
        got = 1'b0;
        @(negedge clk);
        wb_cyc = 1; wb_stb = 1; wb_we = we_; wb_adr = adr; wb_wdat = dat; wb_sel = sel;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack === 1'b1) got = 1'b1;
        end
        n_at = cyc_n;
        rd   = rdat_o;
        wb_cyc = 0; wb_stb = 0; wb_we = 0;
        chk("ack", {31'b0, got}, 32'd1);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                      output int n_at);
        logic [31:0] d;
        xfer(1'b1, adr, dat, sel, d, n_at);
    endtask

    task automatic rd(input logic [31:0] adr, output logic [31:0] d);
        int n;
        xfer(1'b0, adr, 32'h0, 4'hF, d, n);
    endtask

    task automatic wait_to(input int target);
        while (cyc_n < target) @(negedge clk);
    endtask

    task automatic wait_irq(input string tag, input int bound);
        int k;
        k = 0;
        @(negedge clk);
        while (irq !== 1'b1 && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk(tag, {31'b0, irq}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // Compare one recorded frame starting at log index s against 8N1 framing.
    task automatic chk_frame(input string tag, input int s, input logic [7:0] b, input int d);
        logic [9:0] f;
        int bad;
        f   = {1'b1, b, 1'b0};
        bad = -1;
        for (int i = 0; i < 10 * d; i++)
            if (bad < 0 && (s + i >= LOGN || txlog[s + i] !== f[i / d])) bad = i;
        n_tests++;
        assert (bad < 0) else begin
            n_fail++;
            $error("FAIL %s: byte %h div %0d wrong at cycle offset %0d (observed %b expected %b)",
                   tag, b, d, bad, txlog[s + bad], f[bad / d]);
        end
    endtask

    function automatic int find_fall(input int from, input int lim);
        for (int k = from; k <= from + lim; k++)
            if (k < LOGN && txlog[k] === 1'b0) return k;
        return -1;
    endfunction

    // Check a burst of back-to-back frames: first starts at s0, each next
    // one begins at most one idle cycle after the previous stop bit.
    task automatic chk_burst(input string tag, input int s0, input logic [7:0] q[$], input int d);
        int s;
        s = s0;
        foreach (q[k]) begin
            if (k > 0) begin
                s = find_fall(s + 10 * d, 1);
                chk({tag, "_gap"}, {31'b0, s >= 0}, 32'd1);
                if (s < 0) return;
            end
            chk_frame(tag, s, q[k], d);
        end
    endtask

    initial begin
        logic [31:0] d;
        int n, n0, r;
        logic [7:0] q[$];
        logic [7:0] b;
        int dv, nb, zeros;

        rst = 1; wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_sel = 0; wb_adr = 0; wb_wdat = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", {31'b0, tx_o}, 32'd1);
        chk("rst_oeb", {31'b0, tx_oeb}, 32'd0);
        chk("rst_ack", {31'b0, ack}, 32'd0);
        chk("rst_dat", rdat_o, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd1);
        rst = 0;

        rd(BASE + 32'h4, d); chk("status_rst", d, st_exp(0, 0, 0));
        rd(BASE + 32'h8, d); chk("div_rst", d, 32'd16);
        rd(BASE + 32'h0, d); chk("data_read0", d, 32'd0);

        // DIV=4, byte A5: line falls two edges after the write is sampled.
        wr(BASE + 32'h8, 32'd4, 4'b0011, n);
        wr(BASE + 32'h0, 32'hA5, 4'b0001, n);
        chk("a5_irq_busy", {31'b0, irq}, 32'd0);
        wait_to(n + 45);
        chk("a5_pre", {31'b0, txlog[n + 1]}, 32'd1);
        chk("a5_fall", {31'b0, txlog[n + 2]}, 32'd0);
        chk_frame("a5", n + 2, 8'hA5, 4);
        chk("a5_post", {31'b0, txlog[n + 42]}, 32'd1);
        chk("a5_irq_done", {31'b0, irq}, 32'd1);

        // DIV=16, five back-to-back bytes fill a depth-4 FIFO; sixth overflows.
        wr(BASE + 32'h8, 32'd16, 4'b0011, n);
        q = {};
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            wr(BASE + 32'h0, {24'h0, b}, 4'b0001, n);
            if (i == 0) n0 = n;
        end
        rd(BASE + 32'h4, d); chk("status_full", d, st_exp(1, 4, 0));
        wr(BASE + 32'h0, 32'h5A, 4'b0001, n);
        rd(BASE + 32'h4, d); chk("status_ovf", d, st_exp(1, 4, 1));
        wr(BASE + 32'h4, 32'h8, 4'b0001, n);
        rd(BASE + 32'h4, d); chk("status_ovf_clr", d, st_exp(1, 4, 0));
        wait_irq("burst_drain", 1200);
        chk_burst("burst", n0 + 2, q, 16);
        rd(BASE + 32'h4, d); chk("status_drained", d, st_exp(0, 0, 0));

        // DIV=0 runs as 1 cycle per bit.
        wr(BASE + 32'h8, 32'd0, 4'b0011, n);
        wr(BASE + 32'h0, 32'hFF, 4'b0001, n);
        wait_to(n + 16);
        chk("div0_pre", {31'b0, txlog[n + 1]}, 32'd1);
        chk_frame("div0", n + 2, 8'hFF, 1);
        chk("div0_post", {31'b0, txlog[n + 12]}, 32'd1);

        // DIV change mid-frame applies to the next frame only.
        wr(BASE + 32'h8, 32'd4, 4'b0011, n);
        wr(BASE + 32'h0, 32'h3C, 4'b0001, n0);
        wr(BASE + 32'h8, 32'd2, 4'b0011, n);
        wr(BASE + 32'h0, 32'hC3, 4'b0001, n);
        wait_irq("divchg_drain", 200);
        q = {8'h3C};
        chk_burst("divchg_a", n0 + 2, q, 4);
        r = find_fall(n0 + 2 + 40, 1);
        chk("divchg_gap", {31'b0, r >= 0}, 32'd1);
        if (r >= 0) chk_frame("divchg_b", r, 8'hC3, 2);

        // Reset during data bit 3 with two bytes queued.
        wr(BASE + 32'h8, 32'd4, 4'b0011, n);
        wr(BASE + 32'h0, 32'h00, 4'b0001, n0);
        wr(BASE + 32'h0, 32'h11, 4'b0001, n);
        wr(BASE + 32'h0, 32'h22, 4'b0001, n);
        wait_to(n0 + 2 + 16 + 1);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_tx", {31'b0, tx_o}, 32'd1);
        chk("midrst_ack", {31'b0, ack}, 32'd0);
        r = cyc_n;
        rst = 0;
        rd(BASE + 32'h4, d); chk("midrst_status", d, st_exp(0, 0, 0));
        rd(BASE + 32'h8, d); chk("midrst_div", d, 32'd16);
        repeat (200) @(negedge clk);
        zeros = 0;
        for (int k = r; k < cyc_n; k++) if (txlog[k] !== 1'b1) zeros++;
        chk("midrst_quiet", zeros, 32'd0);

        // Unmapped offset, out-of-window reads and writes.
        rd(BASE + 32'hC, d); chk("unmapped_rd", d, 32'd0);
        rd(BASE + 32'h100, d); chk("outside_rd", d, 32'd0);
        wr(BASE + 32'h108, 32'd3, 4'b0011, n);
        rd(BASE + 32'h8, d); chk("outside_div_wr", d, 32'd16);
        wr(BASE + 32'h100, 32'h77, 4'b0001, n);
        rd(BASE + 32'h4, d); chk("outside_data_wr", d, st_exp(0, 0, 0));

        // Held strobe: ack is a single-cycle pulse.
        @(negedge clk);
        wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = BASE + 32'h100; wb_sel = 4'hF;
        @(posedge clk); @(negedge clk);
        chk("held_ack1", {31'b0, ack}, 32'd1);
        chk("held_dat", rdat_o, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("held_ack0", {31'b0, ack}, 32'd0);
        wb_cyc = 0; wb_stb = 0;
        repeat (2) @(negedge clk);

        // Randomized bursts against the framing model.
        for (int rnd = 0; rnd < 6; rnd++) begin
            dv = $urandom_range(1, 6);
            nb = $urandom_range(1, 4);
            wr(BASE + 32'h8, dv, 4'b0011, n);
            q = {};
            for (int i = 0; i < nb; i++) begin
                b = 8'($urandom);
                q.push_back(b);
                wr(BASE + 32'h0, {24'h0, b}, 4'b0001, n);
                if (i == 0) n0 = n;
            end
            wait_irq("rnd_drain", 400);
            chk("rnd_pre", {31'b0, txlog[n0 + 1]}, 32'd1);
            chk_burst("rnd", n0 + 2, q, dv);
            rd(BASE + 32'h4, d); chk("rnd_status", d, st_exp(0, 0, 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
